// File: rtl/bcd_clock_core.sv
// 24-hour BCD time-of-day counter with RUN / SET_HOUR / SET_MIN mode control.
// Optional field blinking in set states is enabled by defining SET_BLINK_EN.
module bcd_clock_core #(
  parameter int TICK_DIV = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        mode_btn,
  input  logic        inc_btn,
  output logic [15:0] data,
  output logic [7:0]  sec_bcd,
  output logic        sec_tick,
  output logic        colon,
  output logic [1:0]  mode
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d, mode_prev_q, mode_prev_d;
  logic            inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d, inc_prev_q, inc_prev_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic            sec_tick_q, sec_tick_d;
  logic            colon_q, colon_d;
  logic [15:0]     data_q, data_d;
  logic            mode_press, inc_press;
  logic [8:0]      sec_nx, min_nx;

  // Increment a 00..59 BCD pair; bit 8 is the carry out of 59 -> 00.
  function automatic logic [8:0] inc_bcd60(input logic [7:0] v);
    if (v[3:0] != 4'd9)      return {1'b0, v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] != 4'd5) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                     return {1'b1, 8'h00};
  endfunction

  function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
    if (v == 8'h23)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign mode_press = mode_s2_q & ~mode_prev_q;
  assign inc_press  = inc_s2_q & ~inc_prev_q;

`ifdef SET_BLINK_EN
  localparam int HALF = (TICK_DIV >= 2) ? TICK_DIV / 2 : 1;
  logic [PW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  // Blink timer restarts whenever the edited field changes or a value is bumped.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (state_d == ST_RUN || state_d != state_q || inc_press) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == PW'(HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  always_comb begin
    mode_s1_d   = mode_btn;
    mode_s2_d   = mode_s1_q;
    mode_prev_d = mode_s2_q;
    inc_s1_d    = inc_btn;
    inc_s2_d    = inc_s1_q;
    inc_prev_d  = inc_s2_q;
    state_d     = state_q;
    presc_d     = presc_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    sec_tick_d  = 1'b0;
    colon_d     = colon_q;
    sec_nx      = inc_bcd60(sec_q);
    min_nx      = inc_bcd60(min_q);

    // A mode press always wins over counting and over a coincident inc press.
    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_SET_HOUR;
          colon_d = 1'b1;
        end else if (run) begin
          if (presc_q == PW'(TICK_DIV - 1)) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            colon_d    = ~colon_q;
            sec_d      = sec_nx[7:0];
            if (sec_nx[8]) begin
              min_d = min_nx[7:0];
              if (min_nx[8]) hour_d = inc_bcd24(hour_q);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      ST_SET_HOUR: begin
        if (mode_press)     state_d = ST_SET_MIN;
        else if (inc_press) hour_d  = inc_bcd24(hour_q);
      end
      ST_SET_MIN: begin
        if (mode_press) begin
          state_d = ST_RUN;
          sec_d   = 8'h00;
          presc_d = '0;
        end else if (inc_press) begin
          min_d = min_nx[7:0];
        end
      end
      default: state_d = ST_RUN;
    endcase

    data_d = {hour_d, min_d};
`ifdef SET_BLINK_EN
    if (phase_d && state_d == ST_SET_HOUR) data_d[15:8] = 8'hFF;
    if (phase_d && state_d == ST_SET_MIN)  data_d[7:0]  = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      inc_s1_q    <= 1'b0;
      inc_s2_q    <= 1'b0;
      inc_prev_q  <= 1'b0;
      presc_q     <= '0;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      sec_tick_q  <= 1'b0;
      colon_q     <= 1'b0;
      data_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      mode_s1_q   <= mode_s1_d;
      mode_s2_q   <= mode_s2_d;
      mode_prev_q <= mode_prev_d;
      inc_s1_q    <= inc_s1_d;
      inc_s2_q    <= inc_s2_d;
      inc_prev_q  <= inc_prev_d;
      presc_q     <= presc_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sec_tick_q  <= sec_tick_d;
      colon_q     <= colon_d;
      data_q      <= data_d;
    end
  end

  assign data     = data_q;
  assign sec_bcd  = sec_q;
  assign sec_tick = sec_tick_q;
  assign colon    = colon_q;
  assign mode     = state_q;

endmodule

// File: tb/tb_bcd_clock_core.sv
// Randomised and directed bench for bcd_clock_core against a time-of-day reference model.
module tb_bcd_clock_core;

  localparam int TICK_DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic [15:0] data;
  logic [7:0]  sec_bcd;
  logic        sec_tick;
  logic        colon;
  logic [1:0]  mode;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bcd_clock_core #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .data(data), .sec_bcd(sec_bcd), .sec_tick(sec_tick), .colon(colon), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer hours/minutes/seconds and a mode number.
  int m_h, m_m, m_s, m_presc, m_mode, m_colon, m_tick;
  int m_ms1, m_ms2, m_mprev, m_is1, m_is2, m_iprev;
  int m_bcnt, m_phase;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [15:0] exp_data();
    logic [15:0] d;
    d = {to_bcd(m_h), to_bcd(m_m)};
`ifdef SET_BLINK_EN
    if (m_phase == 1 && m_mode == 1) d[15:8] = 8'hFF;
    if (m_phase == 1 && m_mode == 2) d[7:0]  = 8'hFF;
`endif
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int mp, ip, old_mode;
    if (!rst_n) begin
      m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_mode = 0; m_colon = 0; m_tick = 0;
      m_ms1 = 0; m_ms2 = 0; m_mprev = 0; m_is1 = 0; m_is2 = 0; m_iprev = 0;
      m_bcnt = 0; m_phase = 0;
    end else begin
      mp = (m_ms2 == 1 && m_mprev == 0) ? 1 : 0;
      ip = (m_is2 == 1 && m_iprev == 0) ? 1 : 0;
      m_mprev = m_ms2; m_ms2 = m_ms1; m_ms1 = int'(mode_btn);
      m_iprev = m_is2; m_is2 = m_is1; m_is1 = int'(inc_btn);
      m_tick = 0;
      old_mode = m_mode;
      if (m_mode == 0) begin
        if (mp == 1) begin
          m_mode = 1; m_colon = 1;
        end else if (run) begin
          if (m_presc == TICK_DIV - 1) begin
            m_presc = 0; m_tick = 1; m_colon = 1 - m_colon;
            m_s++;
            if (m_s == 60) begin
              m_s = 0; m_m++;
              if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
            end
          end else m_presc++;
        end
      end else if (m_mode == 1) begin
        if (mp == 1) m_mode = 2;
        else if (ip == 1) m_h = (m_h + 1) % 24;
      end else begin
        if (mp == 1) begin m_mode = 0; m_s = 0; m_presc = 0; end
        else if (ip == 1) m_m = (m_m + 1) % 60;
      end
      if (m_mode == 0 || m_mode != old_mode || ip == 1) begin
        m_bcnt = 0; m_phase = 0;
      end else if (m_bcnt == TICK_DIV / 2 - 1) begin
        m_bcnt = 0; m_phase = 1 - m_phase;
      end else m_bcnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data", 32'(data), 32'(exp_data()));
      chk("sec_bcd", 32'(sec_bcd), 32'(to_bcd(m_s)));
      chk("sec_tick", 32'(sec_tick), 32'(m_tick));
      chk("colon", 32'(colon), 32'(m_colon));
      chk("mode", 32'(mode), 32'(m_mode));
    end
  end

  task automatic press(input bit is_mode, input int hold);
    @(negedge clk);
    if (is_mode) mode_btn = 1'b1; else inc_btn = 1'b1;
    repeat (hold) @(negedge clk);
    mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int nblank;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h0000);
    chk("rst_sec", 32'(sec_bcd), 32'h00);
    chk("rst_tick", 32'(sec_tick), 32'h0);
    chk("rst_colon", 32'(colon), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    rst_n = 1'b1; run = 1'b1; chk_en = 1'b1;

    // First second after reset
    repeat (10) @(negedge clk);
    chk("t1_tick", 32'(sec_tick), 32'h1);
    chk("t1_sec", 32'(sec_bcd), 32'h01);
    chk("t1_colon", 32'(colon), 32'h1);
    chk("t1_data", 32'(data), 32'h0000);

    // Set 23:59, then let seconds run to the midnight rollover
    press(1'b1, 1);
    repeat (23) press(1'b0, 1);
    press(1'b1, 1);
    repeat (59) press(1'b0, 1);
    press(1'b1, 1);
    for (int k = 0; k < 1000 && sec_bcd != 8'h58; k++) @(negedge clk);
    chk("wait_58", 32'(sec_bcd), 32'h58);
    chk("at_58_data", 32'(data), 32'h2359);
    repeat (10) @(negedge clk);
    chk("sec_59", 32'(sec_bcd), 32'h59);
    chk("data_2359", 32'(data), 32'h2359);
    repeat (10) @(negedge clk);
    chk("sec_00", 32'(sec_bcd), 32'h00);
    chk("data_0000", 32'(data), 32'h0000);
    chk("roll_tick", 32'(sec_tick), 32'h1);

    // Hour setting: 25 presses wrap to 01, a long hold adds one
    press(1'b1, 1);
    chk("set_hour_mode", 32'(mode), 32'h1);
    repeat (25) press(1'b0, 1);
    chk("hour_25", 32'(data), 32'h0100);
    press(1'b0, 20);
    press(1'b1, 1);
    chk("set_min_mode", 32'(mode), 32'h2);
    chk("long_hold", 32'(data[15:8]), 32'h02);
    repeat (61) press(1'b0, 1);
    chk("min_61", 32'(data), 32'h0201);

    // Exit to RUN: seconds cleared, first tick TICK_DIV cycles later
    @(negedge clk) mode_btn = 1'b1;
    for (int k = 0; k < 10 && mode != 2'b00; k++) @(negedge clk);
    mode_btn = 1'b0;
    chk("exit_mode", 32'(mode), 32'h0);
    chk("exit_sec", 32'(sec_bcd), 32'h00);
    n = 0;
    do begin @(negedge clk); n++; end while (!sec_tick && n < 50);
    chk("first_tick", 32'(n), 32'd10);

    // Coincident mode and inc presses in SET_HOUR
    press(1'b1, 1);
    @(negedge clk) begin mode_btn = 1'b1; inc_btn = 1'b1; end
    repeat (2) @(negedge clk);
    mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("both_mode", 32'(mode), 32'h2);
    chk("both_hour", 32'(data[15:8]), 32'h02);
    press(1'b1, 1);

    // Pause in RUN
    run = 1'b0;
    n = 0;
    repeat (50) begin @(negedge clk); if (sec_tick) n++; end
    chk("pause_ticks", 32'(n), 32'h0);
    chk("pause_data", 32'(data), 32'h0201);
    chk("pause_sec", 32'(sec_bcd), 32'h00);
    run = 1'b1;

    // Asynchronous reset in SET_MIN
    press(1'b1, 1);
    press(1'b1, 1);
    chk("pre_rst_mode", 32'(mode), 32'h2);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_mode", 32'(mode), 32'h0);
    chk("arst_data", 32'(data), 32'h0000);
    chk("arst_colon", 32'(colon), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tick", 32'(sec_tick), 32'h0);
    chk("post_rst_mode", 32'(mode), 32'h0);

`ifdef SET_BLINK_EN
    press(1'b1, 1);
    repeat (12) press(1'b0, 1);
    press(1'b1, 1);
    repeat (34) press(1'b0, 1);
    press(1'b1, 1);
    press(1'b1, 1);
    nblank = 0;
    repeat (20) begin
      @(negedge clk);
      if (data == 16'hFF34) nblank++;
      else chk("blink_vis", 32'(data), 32'h1234);
    end
    chk("blink_cnt", 32'(nblank), 32'd10);
    press(1'b1, 1);
    press(1'b1, 1);
`else
    nblank = 0;
`endif

    // Random stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      run = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 5) == 0) inc_btn = ~inc_btn;
      if ($urandom_range(0, 1499) == 0) begin
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
    end
    mode_btn = 1'b0; inc_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_clock_core.md
Name: bcd_clock_core

Overview:
- 24-hour BCD time-of-day counter for the clock design; sits directly upstream of the 4-digit seven-segment display driver.
- Drives the driver's 16-bit data input with {hour tens, hour ones, minute tens, minute ones}, one BCD nibble per digit.
- Provides a run/set mode state machine driven by two already-debounced push-buttons.

Parameters:
- TICK_DIV, 100000000, clk cycles per second (100 MHz board clock); benches override it with a small value.

Ports:
- clk        input   1   system clock, rising edge
- rst_n      input   1   asynchronous active-low reset
- run        input   1   level; 1 = time advances in RUN, 0 = paused
- mode_btn   input   1   debounced level button, asynchronous to clk
- inc_btn    input   1   debounced level button, asynchronous to clk
- data       output  16  {h_t, h_o, m_t, m_o}, BCD; feeds display driver data
- sec_bcd    output  8   {s_t, s_o}, BCD seconds
- sec_tick   output  1   one-cycle pulse on each seconds update
- colon      output  1   toggles on each sec_tick; held 1 in set states
- mode       output  2   00 RUN, 01 SET_HOUR, 10 SET_MIN

Behaviour:
- Reset (rst_n=0, asynchronous): all time counters 0, prescaler 0, state RUN, button sync flops 0.
  - Outputs at reset: data=16'h0000, sec_bcd=8'h00, sec_tick=0, colon=0, mode=2'b00.
- Buttons:
  - Each button passes through a 2-flop synchronizer plus a previous-value flop.
  - Press pulse = sync & ~prev (rising edge only); a held button gives exactly one pulse.
  - An input going high between edges produces a visible effect after the 3rd following rising edge of clk.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when state=RUN and run=1; otherwise it holds its value.
  - At count TICK_DIV-1 it wraps to 0 and seconds advance on that same edge.
  - sec_tick is registered and is high for exactly the cycle in which the new seconds value is present.
- Counting (RUN):
  - s_o 0..9; at 9 it wraps and increments s_t.
  - s_t 0..5; 59 wraps to 00 and carries to minutes.
  - Minutes follow the same rule; 59 carries to hours.
  - Hours count 00..23; 23:59:59 -> 00:00:00.
  - Every nibble is always a legal BCD digit; no value above 9 (or above 5 / 2 for tens digits) may ever appear.
- FSM: RUN -(mode press)-> SET_HOUR -(mode press)-> SET_MIN -(mode press)-> RUN.
- SET_HOUR: each inc press sets hours +1, 23 -> 00. Minutes and seconds are unchanged.
- SET_MIN: each inc press sets minutes +1, 59 -> 00, with no carry into hours.
- Leaving SET_MIN for RUN: seconds set to 00 and prescaler set to 0 on that edge, so the first tick comes TICK_DIV cycles later.
- Set states: prescaler frozen, sec_tick=0, colon=1.
- In RUN, colon toggles on each sec_tick.
- A mode press and an inc press in the same cycle: mode wins and the inc press is discarded.
- inc presses in RUN are ignored.
- run=0 in RUN: counters and prescaler hold; resuming continues from the held prescaler value.
- Reset asserted mid-operation, including in a set state, returns to the reset values immediately; no pulse is generated when it releases.
- data, sec_bcd and mode come straight from registers (no combinational path from inputs).

Optional Feature:
- Macro SET_BLINK_EN.
- Defined:
  - A blink counter runs only in set states.
  - It is cleared, with phase=0, on entry to either set state.
  - Phase toggles every TICK_DIV/2 cycles.
  - While phase=1, the field being edited reads 4'hF in both of its nibbles in data; the display driver shows 4'hF as blank.
  - Any inc press resets phase to 0 (field visible) and clears the blink counter.
  - In RUN, data is never blanked.
- Not defined: data always shows the true counters; no blink logic is present.

Test Plan (TICK_DIV=10):
- Reset, run=1, wait 10 cycles -> sec_tick pulses once, sec_bcd=8'h01, colon=1, data=16'h0000.
- Force time 23:59:58 through set mode plus ticks, run 20 cycles -> sec_bcd 59 then 00, data=16'h0000, carries correct on the same edge.
- mode press once, inc press 25 times -> mode=01, hours 00..23 then 00, 01; 25 presses total leave data=16'h0100; one long held press adds only 1.
- Second mode press, 61 inc presses from 00 -> minutes=01, hours unchanged.
  - Third mode press -> mode=00, sec_bcd=8'h00, first sec_tick exactly 10 cycles later.
- mode and inc pressed on the same cycle while in SET_HOUR -> mode=10, hours unchanged.
  - run=0 in RUN for 50 cycles -> no sec_tick and no change in any counter.
- Assert rst_n low mid-SET_MIN -> mode=00 and data=16'h0000 immediately.
  - With SET_BLINK_EN, in SET_HOUR at 12:34 -> data alternates 16'h1234 and 16'hFF34 every 5 cycles.
